pipeline_ctrl: RTL and testbench



---
 rtl/pipeline_pkg.sv | 41 ++++
 rtl/sat_counter.sv | 33 +++
 rtl/pipeline_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared state and stage-control types for pipeline_ctrl
package pipeline_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        DWAIT = 2'd2,
        HALT  = 2'd3
    } pipe_state_t;

    typedef struct packed {
        logic en_f;
        logic en_d;
        logic en_e;
        logic en_m;
        logic flush_d;
        logic flush_e;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_FREEZE   = 6'b0000_00;
    localparam stage_ctrl_t CTRL_RUN      = 6'b1111_00;
    localparam stage_ctrl_t CTRL_BUBBLE_E = 6'b0011_01;
    localparam stage_ctrl_t CTRL_FLUSH    = 6'b1111_11;
    localparam stage_ctrl_t CTRL_INIT     = 6'b0000_11;

    // Controls for a cycle in which M is free to advance. A flush kills the
    // instruction that a stall or imem miss would otherwise hold, so it wins.
    function automatic stage_ctrl_t advance_ctrl(input logic flush_req,
                                                 input logic stall_req,
                                                 input logic imem_ready);
        stage_ctrl_t c;
        if (flush_req)
            c = CTRL_FLUSH;
        else if (stall_req || !imem_ready)
            c = CTRL_BUBBLE_E;
        else
            c = CTRL_RUN;
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Ports: clk, rst_n (async, active-low), clr (has priority), inc, cnt.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != '1))
            cnt_d = cnt_q + WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline sequencer: stage enables, bubbles, flushes, dmem watchdog
// Inputs : clk, rst_n (async, active-low), stall_req, flush_req, imem_ready,
//          dmem_req_m, dmem_ready, halt_req.
// Outputs: en_f/en_d/en_e/en_m stage-register enables, flush_d/flush_e NOP inserts,
//          halted (HALT state), timeout (sticky, HALT reached via dmem watchdog).
// Macro PIPELINE_CTRL_PERF_EN adds stall_cycles, flush_cycles, wait_cycles.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int INIT_CYCLES  = 3,
    parameter int WAIT_TIMEOUT = 255,
    parameter int WAIT_W       = 8,
    parameter int CNT_W        = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall_req,
    input  logic flush_req,
    input  logic imem_ready,
    input  logic dmem_req_m,
    input  logic dmem_ready,
    input  logic halt_req,
    output logic en_f,
    output logic en_d,
    output logic en_e,
    output logic en_m,
    output logic flush_d,
    output logic flush_e,
    output logic halted,
    output logic timeout
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles,
    output logic [CNT_W-1:0] wait_cycles
`endif
);

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);

    if (INIT_CYCLES < 1 || WAIT_TIMEOUT < 1 || CNT_W < 1) begin : g_param_check
        $error("pipeline_ctrl: INIT_CYCLES, WAIT_TIMEOUT and CNT_W must be >= 1");
    end

    pipe_state_t       state_q, state_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic              timeout_q, timeout_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_inc, wait_clr;
    logic              cnt_stall, cnt_flush;
    stage_ctrl_t       ctrl, adv;

    assign adv = advance_ctrl(flush_req, stall_req, imem_ready);

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        timeout_d  = timeout_q;
        ctrl       = CTRL_FREEZE;
        wait_inc   = 1'b0;
        wait_clr   = 1'b0;
        cnt_stall  = 1'b0;
        cnt_flush  = 1'b0;
        unique case (state_q)
            INIT: begin
                ctrl = CTRL_INIT;
                if (init_cnt_q == INIT_LAST)
                    state_d = RUN;
                else
                    init_cnt_d = init_cnt_q + INIT_W'(1);
            end
            RUN: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (dmem_req_m && !dmem_ready) begin
                    // wait_cnt is always 0 in RUN, so this makes it 1.
                    state_d  = DWAIT;
                    wait_inc = 1'b1;
                end else begin
                    ctrl      = adv;
                    cnt_flush = flush_req;
                    cnt_stall = !flush_req && (stall_req || !imem_ready);
                end
            end
            DWAIT: begin
                // E is frozen, so stall/flush requests re-present on exit.
                if (dmem_ready) begin
                    ctrl      = adv;
                    cnt_flush = flush_req;
                    cnt_stall = !flush_req && (stall_req || !imem_ready);
                    state_d   = RUN;
                    wait_clr  = 1'b1;
                end else begin
                    wait_inc = 1'b1;
                    // wait_cnt+1 wait cycles will have elapsed after this one.
                    if (wait_cnt >= WAIT_LAST) begin
                        state_d   = HALT;
                        timeout_d = 1'b1;
                    end
                end
            end
            HALT: begin
                ctrl = CTRL_FREEZE;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wait_clr),
        .inc   (wait_inc),
        .cnt   (wait_cnt)
    );

`ifdef PIPELINE_CTRL_PERF_EN
    sat_counter #(.WIDTH(CNT_W)) u_stall_cycles (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(cnt_stall), .cnt(stall_cycles)
    );
    sat_counter #(.WIDTH(CNT_W)) u_flush_cycles (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(cnt_flush), .cnt(flush_cycles)
    );
    sat_counter #(.WIDTH(CNT_W)) u_wait_cycles (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(state_q == DWAIT), .cnt(wait_cycles)
    );
`else
    logic unused_perf;
    assign unused_perf = cnt_stall ^ cnt_flush;
`endif

    assign en_f    = ctrl.en_f;
    assign en_d    = ctrl.en_d;
    assign en_e    = ctrl.en_e;
    assign en_m    = ctrl.en_m;
    assign flush_d = ctrl.flush_d;
    assign flush_e = ctrl.flush_e;
    assign halted  = (state_q == HALT);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed vector bench for pipeline_ctrl
module tb_pipeline_ctrl;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic stall_req, flush_req, imem_ready, dmem_req_m, dmem_ready, halt_req;
    logic en_f, en_d, en_e, en_m, flush_d, flush_e, halted, timeout;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles, flush_cycles, wait_cycles;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .INIT_CYCLES  (3),
        .WAIT_TIMEOUT (5),
        .WAIT_W       (8),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_req  (stall_req),
        .flush_req  (flush_req),
        .imem_ready (imem_ready),
        .dmem_req_m (dmem_req_m),
        .dmem_ready (dmem_ready),
        .halt_req   (halt_req),
        .en_f       (en_f),
        .en_d       (en_d),
        .en_e       (en_e),
        .en_m       (en_m),
        .flush_d    (flush_d),
        .flush_e    (flush_e),
        .halted     (halted),
        .timeout    (timeout)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles),
        .wait_cycles  (wait_cycles)
`endif
    );

    // inputs: {stall, flush, imem_ready, dmem_req_m, dmem_ready, halt_req}
    // expect: {en_f, en_d, en_e, en_m, flush_d, flush_e, halted, timeout}
    typedef struct {
        logic [5:0] in;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[19];

    function automatic logic [7:0] obs();
        return {en_f, en_d, en_e, en_m, flush_d, flush_e, halted, timeout};
    endfunction

    task automatic drive(input logic [5:0] in);
        {stall_req, flush_req, imem_ready, dmem_req_m, dmem_ready, halt_req} = in;
    endtask

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, got, exp);
        end
    endtask

    task automatic check_cnt(input string nm, input logic [CNT_W-1:0] got,
                             input logic [CNT_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Release reset just after an edge and sit through the three INIT cycles.
    task automatic reset_to_run();
        rst_n = 1'b0;
        drive(6'b001000);
        next_cycle();
        rst_n = 1'b1;
        repeat (3) next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected $finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vt[0]  = '{6'b001000, 8'b000011_00};  // INIT cycle 1
        vt[1]  = '{6'b001000, 8'b000011_00};  // INIT cycle 2
        vt[2]  = '{6'b001000, 8'b000011_00};  // INIT cycle 3
        vt[3]  = '{6'b001000, 8'b111100_00};  // RUN
        vt[4]  = '{6'b101000, 8'b001101_00};  // load-use stall
        vt[5]  = '{6'b001000, 8'b111100_00};
        vt[6]  = '{6'b111000, 8'b111111_00};  // flush beats stall
        vt[7]  = '{6'b000000, 8'b001101_00};  // imem miss -> bubble
        vt[8]  = '{6'b010000, 8'b111111_00};  // flush ignores imem miss
        vt[9]  = '{6'b001110, 8'b111100_00};  // dmem ready at once
        vt[10] = '{6'b001100, 8'b000000_00};  // dmem wait 1
        vt[11] = '{6'b101100, 8'b000000_00};  // wait 2, stall ignored
        vt[12] = '{6'b011100, 8'b000000_00};  // wait 3, flush ignored
        vt[13] = '{6'b001100, 8'b000000_00};  // wait 4
        vt[14] = '{6'b101110, 8'b001101_00};  // ready: stall re-presented
        vt[15] = '{6'b001000, 8'b111100_00};  // back in RUN
        vt[16] = '{6'b011001, 8'b000000_00};  // halt_req beats flush
        vt[17] = '{6'b011000, 8'b000000_10};  // HALT, flush no effect
        vt[18] = '{6'b001000, 8'b000000_10};

        rst_n = 1'b0;
        drive(6'b001000);
        #2;
        check("reset_state", obs(), 8'b000011_00);
        repeat (2) next_cycle();
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(vt[i].in);
            @(negedge clk);
            check($sformatf("vec%0d", i), obs(), vt[i].exp);
            next_cycle();
        end

        // Asynchronous reset out of HALT, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_from_halt", obs(), 8'b000011_00);

        // Watchdog: five wait cycles then HALT with timeout.
        reset_to_run();
        drive(6'b001100);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("wdog_wait%0d", k + 1), obs(), 8'b000000_00);
            next_cycle();
        end
        @(negedge clk);
        check("wdog_halt", obs(), 8'b000000_11);
        next_cycle();
        drive(6'b011000);
        @(negedge clk);
        check("wdog_halt_flush_ignored", obs(), 8'b000000_11);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_clears_timeout", obs(), 8'b000011_00);

`ifdef PIPELINE_CTRL_PERF_EN
        reset_to_run();
        drive(6'b101000); next_cycle();
        drive(6'b001000); next_cycle();
        drive(6'b000000); next_cycle();
        drive(6'b011000); next_cycle();
        drive(6'b001001); next_cycle();
        drive(6'b001000);
        @(negedge clk);
        check("perf_halted", obs(), 8'b000000_10);
        check_cnt("stall_cycles", stall_cycles, 32'd2);
        check_cnt("flush_cycles", flush_cycles, 32'd1);
        check_cnt("wait_cycles", wait_cycles, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
